sequence_transmitter: RTL and testbench
=======================================

# sequence_transmitter

Serial frame transmitter driving the single-bit line `X` that the sequence detector samples. It accepts a parallel word over a valid/ready handshake and emits a frame on `X`: a sync run of zeros, a marker bit, the payload MSB-first with bit-stuffing, then a stop bit. The idle line is held high. A payload zero-run therefore never reproduces the sync pattern, so the detector fires once per frame.

## Interface
- `SYNC_LEN`, 4, number of consecutive `0` bits in the sync run; legal values are 2 and up.
- `DATA_W`, 8, payload width; legal values are 1 and up.
- `CLK`  input  1  rising-edge clock.
- `RESET`  input  1  asynchronous, active-high reset.
- `DIN`  input  DATA_W  payload word, sampled when `LOAD && READY`.
- `LOAD`  input  1  request to send `DIN`.
- `READY`  output  1  high when a new word can be accepted.
- `X`  output  1  serial line, registered.
- `DONE`  output  1  one-cycle pulse, high during the stop bit.
- `state`  output  3  current FSM state, for debug and observation.

## Operation
- **FSM states:** IDLE, SYNC, MARK, DATA, STOP.
- **IDLE:** `X`=1, `READY`=1. When `LOAD` is high at a clock edge, latch `DIN` into the shift register, clear the counters and go to SYNC. `READY` drops on the same edge.
- **SYNC:** `X`=0 for exactly `SYNC_LEN` cycles, then go to MARK.
- **MARK:** `X`=1 for one cycle. This closes the sync run. Clear `zero_run`, then go to DATA.
- **DATA:** payload is sent MSB-first, one bit per cycle.
  - Each transmitted `0` increments `zero_run`; each `1` clears it.
  - If `zero_run` reaches `SYNC_LEN-1` and payload bits remain, the next cycle emits a stuffed `1` without consuming a payload bit, then clears `zero_run`.
  - No stuff bit is inserted after the final payload bit, because STOP supplies the `1`.
  - After the last payload bit, go to STOP.
- **STOP:** `X`=1 for one cycle with `DONE`=1, then go to IDLE.
- **Frame length:** `SYNC_LEN + 1 + DATA_W + stuffed + 1` cycles.
- **`LOAD` outside IDLE:** ignored. `DIN` is not sampled and there is no error flag.
- **Counter widths:** the bit counter is `$clog2(DATA_W+1)` bits and the zero-run counter is `$clog2(SYNC_LEN)` bits. Neither counter wraps within a frame.

## Timing
- **Reset values:** `state`=IDLE, `X`=1, `READY`=1, `DONE`=0, counters=0, shift register=0.
- **Reset mid-frame:** `X` returns to 1 immediately (asynchronous) and the partial frame is discarded. The downstream detector sees at most a truncated sync run.
- **Latency:** the capture edge is edge n. The first sync bit appears on `X` in the cycle following edge n, and `READY`=0 from that cycle.
- **Frame completion:** `DONE` and the stop bit occupy the same cycle. `READY`=1 from the next cycle, with `X`=1 (idle).
- **Back-to-back frames:** with `LOAD` held high, the minimum inter-frame gap is the stop bit plus one idle cycle. In that idle cycle `READY`=1 and the next capture happens at its end.
- **Outputs:** all outputs are registered. There are no combinational paths from `LOAD` or `DIN` to any output.

## Structure
- **Shared package `seq_pkg`:**
  - state enum: IDLE=3'b000, SYNC=3'b001, MARK=3'b011, DATA=3'b010, STOP=3'b110;
  - constant `SEQ_IDLE_LEVEL`=1'b1;
  - default `SEQ_SYNC_LEN`=4, used by both this block and the detector.
- **Module layout:** a single module; no sub-module is needed. The shift register, bit counter, zero-run counter and FSM stay in one sequential process, plus next-state logic.

## Test plan
- **Reset:** assert `RESET` mid-DATA → `X`=1, `state`=IDLE, `READY`=1 and `DONE`=0 asynchronously. After release, a `LOAD` starts a clean frame.
- **`DIN`=8'hA5:** `X` sequence 0000 1 10100101 1, 14 cycles, no stuffing. `DONE` high on cycle 14 and `READY` high on cycle 15.
- **`DIN`=8'h00:** `X` sequence 0000 1 000 1 000 1 00 1, 16 cycles, 2 stuffed bits.
- **`DIN`=8'h0F:** `X` sequence 0000 1 000 1 0 1111 1, 15 cycles, 1 stuffed bit.
- **Back-to-back frames:** hold `LOAD`=1 with words 8'hA5 then 8'h00 → exactly one idle `1` between the stop bit and the next sync. `LOAD` pulses and `DIN` changes mid-frame are ignored.
- **Loopback:** drive the detector from `X` over 100 random words → exactly one detection per frame and none inside any payload.

Source files
------------

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Definitions shared by the sequence transmitter and the sequence detector:
//   seq_state_t    - transmitter FSM state encoding (also visible on the
//                    transmitter's debug `state` port)
//   SEQ_IDLE_LEVEL - level of the serial line when no frame is in flight
//   SEQ_SYNC_LEN   - default length of the sync zero-run, shared so both ends
//                    of the link agree on the pattern
// -----------------------------------------------------------------------------
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'b000,
    SYNC = 3'b001,
    MARK = 3'b011,
    DATA = 3'b010,
    STOP = 3'b110
  } seq_state_t;

  localparam logic SEQ_IDLE_LEVEL = 1'b1;
  localparam int   SEQ_SYNC_LEN   = 4;

endpackage : seq_pkg

// File: rtl/sequence_transmitter.sv
// -----------------------------------------------------------------------------
// sequence_transmitter
// Serialises one DATA_W-bit word per frame onto the line X:
//   SYNC_LEN zeros, a marker 1, the payload MSB-first with a stuffed 1 after
//   every SYNC_LEN-1 consecutive payload zeros (unless the payload is
//   exhausted), then a stop 1. The idle line sits at SEQ_IDLE_LEVEL.
//
// Ports
//   CLK    in   rising-edge clock
//   RESET  in   asynchronous, active-high reset
//   DIN    in   payload word, captured when LOAD && READY at a clock edge
//   LOAD   in   request to send DIN; ignored while a frame is in flight
//   READY  out  registered, high while a new word can be accepted
//   X      out  registered serial line
//   DONE   out  registered one-cycle pulse coinciding with the stop bit
//   state  out  current FSM state (seq_state_t encoding), for observation
// -----------------------------------------------------------------------------
module sequence_transmitter
  import seq_pkg::*;
#(
  parameter int SYNC_LEN = SEQ_SYNC_LEN,
  parameter int DATA_W   = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DIN,
  input  logic              LOAD,
  output logic              READY,
  output logic              X,
  output logic              DONE,
  output logic [2:0]        state
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam int ZR_W = $clog2(SYNC_LEN);

  localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_W);
  localparam logic [ZR_W-1:0] ZR_LIM  = ZR_W'(SYNC_LEN - 1);

  // r_state always names what X carries in the current cycle, so every
  // registered output is computed from the next state and updated together
  // with it; nothing reaches an output combinationally from LOAD or DIN.
  seq_state_t        r_state;
  seq_state_t        w_state_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [BC_W-1:0]   r_bitcnt;
  logic [BC_W-1:0]   w_bitcnt_nxt;
  logic [ZR_W-1:0]   r_zrun;
  logic [ZR_W-1:0]   w_zrun_nxt;
  logic              r_x;
  logic              w_x_nxt;
  logic              r_ready;
  logic              r_done;

  logic              w_bit;
  logic [DATA_W-1:0] w_shift_adv;

  assign w_bit       = r_shift[DATA_W-1];
  assign w_shift_adv = r_shift << 1;

  // Next-state / next-output logic
  always_comb begin
    w_state_nxt  = r_state;
    w_shift_nxt  = r_shift;
    w_bitcnt_nxt = r_bitcnt;
    w_zrun_nxt   = r_zrun;
    w_x_nxt      = SEQ_IDLE_LEVEL;

    case (r_state)
      IDLE: begin
        if (LOAD) begin
          w_state_nxt  = SYNC;
          w_shift_nxt  = DIN;
          w_bitcnt_nxt = '0;
          w_zrun_nxt   = '0;
          w_x_nxt      = 1'b0;
        end
      end

      // While in SYNC the zero-run counter indexes the sync bit on the line;
      // it only needs to reach SYNC_LEN-1, which fits its width.
      SYNC: begin
        if (r_zrun == ZR_LIM) begin
          w_state_nxt = MARK;
          w_zrun_nxt  = '0;
          w_x_nxt     = 1'b1;
        end else begin
          w_zrun_nxt  = r_zrun + ZR_W'(1);
          w_x_nxt     = 1'b0;
        end
      end

      // The marker cleared the run; the first payload bit goes out next.
      MARK: begin
        w_state_nxt  = DATA;
        w_x_nxt      = w_bit;
        w_shift_nxt  = w_shift_adv;
        w_bitcnt_nxt = BC_W'(1);
        w_zrun_nxt   = w_bit ? '0 : ZR_W'(1);
      end

      // The exhausted-payload test comes first so no stuff bit follows the
      // last payload bit; the stop bit already breaks any trailing run.
      DATA: begin
        if (r_bitcnt == BC_LAST) begin
          w_state_nxt = STOP;
          w_x_nxt     = 1'b1;
        end else if (r_zrun == ZR_LIM) begin
          w_x_nxt     = 1'b1;
          w_zrun_nxt  = '0;
        end else begin
          w_x_nxt      = w_bit;
          w_shift_nxt  = w_shift_adv;
          w_bitcnt_nxt = r_bitcnt + BC_W'(1);
          w_zrun_nxt   = w_bit ? '0 : (r_zrun + ZR_W'(1));
        end
      end

      STOP: begin
        w_state_nxt = IDLE;
        w_x_nxt     = SEQ_IDLE_LEVEL;
      end

      default: begin
        w_state_nxt = IDLE;
        w_x_nxt     = SEQ_IDLE_LEVEL;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_zrun   <= '0;
      r_x      <= SEQ_IDLE_LEVEL;
      r_ready  <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_shift  <= w_shift_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_zrun   <= w_zrun_nxt;
      r_x      <= w_x_nxt;
      r_ready  <= (w_state_nxt == IDLE);
      r_done   <= (w_state_nxt == STOP);
    end
  end

  assign X     = r_x;
  assign READY = r_ready;
  assign DONE  = r_done;
  assign state = r_state;

endmodule : sequence_transmitter

// File: tb/tb_sequence_transmitter.sv
// -----------------------------------------------------------------------------
// tb_sequence_transmitter
// Directed frames with known line patterns, back-to-back frames, a mid-frame
// reset and 100 random words compared against a frame-building model. A small
// behavioural detector on X counts sync detections per frame.
// -----------------------------------------------------------------------------
module tb_sequence_transmitter;

  localparam int SYNC_LEN = 4;
  localparam int DATA_W   = 8;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              LOAD;
  logic [DATA_W-1:0] DIN;
  logic              READY;
  logic              X;
  logic              DONE;
  logic [2:0]        state;

  int n_vec = 0;
  int n_err = 0;
  int det_cnt = 0;
  int mon_zeros = 0;
  bit exp_q[$];

  always #5 CLK = ~CLK;

  sequence_transmitter #(.SYNC_LEN(SYNC_LEN), .DATA_W(DATA_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .DIN   (DIN),
    .LOAD  (LOAD),
    .READY (READY),
    .X     (X),
    .DONE  (DONE),
    .state (state)
  );

  // Behavioural detector: a run of at least SYNC_LEN zeros closed by a 1.
  always @(negedge CLK) begin
    if (X === 1'b0) mon_zeros++;
    else begin
      if (mon_zeros >= SYNC_LEN) det_cnt++;
      mon_zeros = 0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line bits from a written pattern; '_' is a visual separator.
  task automatic from_str(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "0") exp_q.push_back(1'b0);
      else if (s[i] == "1") exp_q.push_back(1'b1);
    end
  endtask

  // Frame model: sync zeros, marker, payload MSB-first with a 1 inserted
  // whenever SYNC_LEN-1 zeros in a row have gone out and more payload
  // follows, then the stop bit.
  task automatic model(input logic [DATA_W-1:0] w);
    int zeros;
    exp_q.delete();
    repeat (SYNC_LEN) exp_q.push_back(1'b0);
    exp_q.push_back(1'b1);
    zeros = 0;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      exp_q.push_back(w[i]);
      zeros = w[i] ? 0 : zeros + 1;
      if (zeros == SYNC_LEN - 1 && i > 0) begin
        exp_q.push_back(1'b1);
        zeros = 0;
      end
    end
    exp_q.push_back(1'b1);
  endtask

  // Sends one word and checks every line cycle against exp_q.
  // mode 0: LOAD dropped after capture
  // mode 1: LOAD held high, DIN scrambled mid-frame
  // other : LOAD and DIN randomised mid-frame
  task automatic run_frame(input string tag, input logic [DATA_W-1:0] w, input int mode);
    int t;
    int d0;
    int n;
    t = 0;
    while (READY !== 1'b1 && t < 64) begin
      @(negedge CLK);
      t++;
    end
    chk({tag, " ready_wait"}, READY, 1);
    d0 = det_cnt;
    n  = exp_q.size();
    DIN  = w;
    LOAD = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk($sformatf("%s X[%0d]", tag, i), X, exp_q[i]);
      chk($sformatf("%s DONE[%0d]", tag, i), DONE, (i == n - 1));
      chk($sformatf("%s READY[%0d]", tag, i), READY, 0);
      if (i < SYNC_LEN)       chk($sformatf("%s state[%0d]", tag, i), state, 3'b001);
      else if (i == SYNC_LEN) chk($sformatf("%s state[%0d]", tag, i), state, 3'b011);
      else if (i == n - 1)    chk($sformatf("%s state[%0d]", tag, i), state, 3'b110);
      else                    chk($sformatf("%s state[%0d]", tag, i), state, 3'b010);
      case (mode)
        0:       LOAD = 1'b0;
        1:       begin LOAD = 1'b1; DIN = DATA_W'($urandom); end
        default: begin LOAD = 1'($urandom_range(0, 1)); DIN = DATA_W'($urandom); end
      endcase
    end
    @(negedge CLK);
    chk({tag, " idle X"}, X, 1);
    chk({tag, " idle READY"}, READY, 1);
    chk({tag, " idle DONE"}, DONE, 0);
    chk({tag, " idle state"}, state, 3'b000);
    chk({tag, " detections"}, det_cnt - d0, 1);
    if (mode != 1) LOAD = 1'b0;
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    RESET = 1'b1;
    LOAD  = 1'b0;
    DIN   = '0;
    @(negedge CLK);
    chk("reset X", X, 1);
    chk("reset READY", READY, 1);
    chk("reset DONE", DONE, 0);
    chk("reset state", state, 3'b000);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);

    from_str("0000_1_10100101_1");
    run_frame("a5", 8'hA5, 0);
    from_str("0000_1_000_1_000_1_00_1");
    run_frame("00", 8'h00, 2);
    from_str("0000_1_000_1_0_1111_1");
    run_frame("0f", 8'h0F, 0);

    // Back-to-back with LOAD held high: exactly one idle cycle between frames.
    from_str("0000_1_10100101_1");
    run_frame("b2b_a5", 8'hA5, 1);
    from_str("0000_1_000_1_000_1_00_1");
    run_frame("b2b_00", 8'h00, 1);

    // Reset while a payload zero is on the line.
    DIN  = 8'h00;
    LOAD = 1'b1;
    @(negedge CLK);
    LOAD = 1'b0;
    repeat (SYNC_LEN + 2) @(negedge CLK);
    chk("pre_reset X", X, 0);
    chk("pre_reset state", state, 3'b010);
    #2 RESET = 1'b1;
    #1;
    chk("async_reset X", X, 1);
    chk("async_reset state", state, 3'b000);
    chk("async_reset READY", READY, 1);
    chk("async_reset DONE", DONE, 0);
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    from_str("0000_1_10100101_1");
    run_frame("post_reset_a5", 8'hA5, 0);

    // Random loopback.
    for (int k = 0; k < 100; k++) begin
      w = DATA_W'($urandom);
      model(w);
      run_frame($sformatf("rnd%0d_%02h", k, w), w, (k % 3 == 0) ? 0 : 2);
    end
    LOAD = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_sequence_transmitter
